bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/bcd_adj3.sv | 17 +
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_pkg
//  Description : Shared types and constants for the sequential binary-to-BCD
//                converter (FSM state encoding, nibble width, counter sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

    localparam int BCD_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must be able to hold the value BIN_W itself.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bcd_adj3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_adj3
//  Description : Double-dabble nibble correction: adds 3 to a BCD digit >= 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_adj3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] i_nib,
    output logic [BCD_NIBBLE_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule : bcd_adj3
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative shift-and-add-3 binary-to-BCD converter with
//                valid/ready handshakes, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_W-1:0]             in_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] out_bcd,
    output logic                         busy
);

    localparam int c_CNT_W = cnt_width(BIN_W);
    localparam int c_BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int c_CAT_W = c_BCD_W + BIN_W;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    generate
        if ((BIN_W < 4) || (BIN_W > 16)) begin : g_bad_bin_w
            $error("bin2bcd_seq: BIN_W must be within 4..16");
        end
        if (!((10 ** DIGITS) > ((2 ** BIN_W) - 1))) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small to hold 2**BIN_W-1");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next;
    logic [BIN_W-1:0]     r_sr;
    logic [c_BCD_W-1:0]   r_acc;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   w_adj;
    logic [c_CAT_W-1:0]   w_shift;
    logic                 w_last;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_adj3 u_adj3 (
                .i_nib (r_acc[gi*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
                .o_nib (w_adj[gi*BCD_NIBBLE_W +: BCD_NIBBLE_W])
            );
        end
    endgenerate

    // Corrected accumulator and operand move left as one wide register.
    assign w_shift = {w_adj, r_sr} << 1;
    assign w_last  = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sr  <= in_bin;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_sr  <= w_shift[BIN_W-1:0];
                    r_acc <= w_shift[c_CAT_W-1:BIN_W];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd <= w_shift[c_CAT_W-1:BIN_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SHIFT);
    assign out_bcd   = r_bcd;

endmodule : bin2bcd_seq
`default_nettype wire
